// File: rtl/clock_pkg.sv
// Shared BCD time types, limits and the active-low segment encoder for the clock core.
// Pure definitions: no latency and no flow control.
package clock_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    localparam bcd_pair_t MAX_SEC = '{tens: 4'd5, ones: 4'd9};
    localparam bcd_pair_t MAX_MIN = '{tens: 4'd5, ones: 4'd9};
    localparam bcd_pair_t MAX_HR  = '{tens: 4'd2, ones: 4'd3};

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] seg_encode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Increment a BCD pair, wrapping to 00 after max_val.
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t val, input bcd_pair_t max_val);
        bcd_pair_t res;
        if (val == max_val) begin
            res = '0;
        end else if (val.ones == 4'd9) begin
            res = '{tens: val.tens + 4'd1, ones: 4'd0};
        end else begin
            res = '{tens: val.tens, ones: val.ones + 4'd1};
        end
        return res;
    endfunction

    // Only valid for values up to 31 (hour range).
    function automatic logic [4:0] bcd_to_bin(input bcd_pair_t val);
        return {1'b0, val.tens} * 5'd10 + {1'b0, val.ones};
    endfunction

endpackage

// File: rtl/digit_scan.sv
// Multiplexed digit scanner: one digit per SCAN_DIV-cycle slot, display/anode/sel registered together.
// Latency: a slot's segment value is captured at the slot's first edge; no backpressure, free-running.
module digit_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_DIGITS-1:0][6:0]        segs,
    output logic [6:0]                        display,
    output logic [NUM_DIGITS-1:0]             anode,
    output logic [$clog2(NUM_DIGITS)-1:0]     sel
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            sel      <= '0;
            display  <= SEG_BLANK;
            anode    <= '1;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            // Loading only at slot start keeps each slot's digit value stable for the whole slot.
            if (scan_cnt == '0) begin
                sel     <= idx;
                display <= segs[idx];
                anode   <= ~(NUM_DIGITS'(1) << idx);
            end
        end
    end

endmodule

// File: rtl/digital_clock_core.sv
// BCD time-of-day keeper with 12/24h mapping, set controls and a multiplexed active-low 7-seg driver.
// Latency: time registers update 1 cycle after sec_tick; display refreshes per scan slot; no backpressure.
module digital_clock_core
    import clock_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_12h,
    input  logic                  show_sec,
    input  logic                  set_en,
    input  logic                  inc_min,
    input  logic                  inc_hr,
    output logic [6:0]            display,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  dp,
    output logic                  pm,
    output logic [4:0]            hours,
    output logic                  sec_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0] presc;
    bcd_pair_t     sec_bcd, min_bcd, hr_bcd;
    bcd_pair_t     sec_nxt, min_nxt, hr_nxt;

    assign sec_tick = (presc == PW'(TICK_DIV - 1)) && !set_en;

    always_ff @(posedge clk) begin
        if (!rst || set_en) begin
            presc <= '0;
        end else if (presc == PW'(TICK_DIV - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        sec_nxt = sec_bcd;
        min_nxt = min_bcd;
        hr_nxt  = hr_bcd;
        if (set_en) begin
            sec_nxt = '0;
            if (inc_min) min_nxt = bcd_inc(min_bcd, MAX_MIN);
            if (inc_hr)  hr_nxt  = bcd_inc(hr_bcd, MAX_HR);
        end else if (sec_tick) begin
            sec_nxt = bcd_inc(sec_bcd, MAX_SEC);
            if (sec_bcd == MAX_SEC) begin
                min_nxt = bcd_inc(min_bcd, MAX_MIN);
                if (min_bcd == MAX_MIN) hr_nxt = bcd_inc(hr_bcd, MAX_HR);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sec_bcd <= '0;
            min_bcd <= '0;
            hr_bcd  <= '0;
            hours   <= '0;
        end else begin
            sec_bcd <= sec_nxt;
            min_bcd <= min_nxt;
            hr_bcd  <= hr_nxt;
            hours   <= bcd_to_bin(hr_nxt);
        end
    end

    assign pm = (hours >= 5'd12);

    logic [4:0] disp_hr;
    logic [3:0] disp_tens, disp_ones;
    logic       blank_tens;

    always_comb begin
        disp_hr = hours;
        if (mode_12h) begin
            if (hours == 5'd0)       disp_hr = 5'd12;
            else if (hours > 5'd12)  disp_hr = hours - 5'd12;
        end
        if (disp_hr >= 5'd20) begin
            disp_tens = 4'd2;
            disp_ones = 4'(disp_hr - 5'd20);
        end else if (disp_hr >= 5'd10) begin
            disp_tens = 4'd1;
            disp_ones = 4'(disp_hr - 5'd10);
        end else begin
            disp_tens = 4'd0;
            disp_ones = 4'(disp_hr);
        end
        blank_tens = mode_12h && (disp_hr < 5'd10);
    end

    logic [6:0] hr_t_seg, hr_o_seg, min_t_seg, min_o_seg, sec_t_seg, sec_o_seg;

    assign hr_t_seg  = blank_tens ? SEG_BLANK : seg_encode(disp_tens);
    assign hr_o_seg  = seg_encode(disp_ones);
    assign min_t_seg = seg_encode(min_bcd.tens);
    assign min_o_seg = seg_encode(min_bcd.ones);
    assign sec_t_seg = seg_encode(sec_bcd.tens);
    assign sec_o_seg = seg_encode(sec_bcd.ones);

    logic [NUM_DIGITS-1:0][6:0] segs;

    generate
        if (NUM_DIGITS == 6) begin : g_six
            assign segs = {hr_t_seg, hr_o_seg, min_t_seg, min_o_seg, sec_t_seg, sec_o_seg};
        end else begin : g_four
            assign segs = show_sec ? {min_t_seg, min_o_seg, sec_t_seg, sec_o_seg}
                                   : {hr_t_seg, hr_o_seg, min_t_seg, min_o_seg};
        end
    endgenerate

    logic [IW-1:0] scan_sel;

    digit_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .segs    (segs),
        .display (display),
        .anode   (anode),
        .sel     (scan_sel)
    );

    // Colon point blinks with the first half of each second while digit 2 is lit.
    assign dp = !((scan_sel == IW'(2)) && (presc < PW'(TICK_DIV / 2)));

endmodule

// File: tb/tb_digital_clock_core.sv
// Directed bench for digital_clock_core (TICK_DIV=10, SCAN_DIV=4, 4 digits).
module tb_digital_clock_core;

    logic       clk = 1'b0;
    logic       rst, mode_12h, show_sec, set_en, inc_min, inc_hr;
    logic [6:0] display;
    logic [3:0] anode;
    logic       dp, pm, sec_tick;
    logic [4:0] hours;

    int checks = 0;
    int errors = 0;

    digital_clock_core #(.TICK_DIV(10), .SCAN_DIV(4), .NUM_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .mode_12h(mode_12h), .show_sec(show_sec), .set_en(set_en),
        .inc_min(inc_min), .inc_hr(inc_hr), .display(display), .anode(anode), .dp(dp),
        .pm(pm), .hours(hours), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    // Independent prescaler/second model driven only by bench inputs.
    int m_presc = 0;
    int m_sec   = 0;
    always @(posedge clk) begin
        if (!rst || set_en) m_presc <= 0;
        else                m_presc <= (m_presc == 9) ? 0 : m_presc + 1;
        if (!rst || set_en)    m_sec <= 0;
        else if (m_presc == 9) m_sec <= (m_sec == 59) ? 0 : m_sec + 1;
    end

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        int         hr_n;
        int         min_n;
        logic       m12;
        logic       ss;
        logic [27:0] digs;
        logic       exp_pm;
        logic [4:0] exp_hours;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic read_digit(input int k, output logic [6:0] seg, output int sec_ld);
        logic [3:0] tgt, prev;
        int         prev_sec;
        bit         got;
        tgt = ~(4'b0001 << k);
        got = 1'b0;
        prev = anode;
        prev_sec = m_sec;
        seg = 'x;
        sec_ld = -1;
        for (int i = 0; i < 48 && !got; i++) begin
            @(negedge clk);
            if (anode == tgt && prev != tgt) begin
                seg = display;
                sec_ld = prev_sec;
                got = 1'b1;
            end
            prev = anode;
            prev_sec = m_sec;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL read_digit%0d: timeout, anode %b", k, anode);
        end
    endtask

    task automatic wait_anode(input logic [3:0] tgt);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (anode == tgt) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_anode: timeout, got %b, expected %b", anode, tgt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; set_en = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            inc_min = 1'b1; @(negedge clk);
            inc_min = 1'b0; @(negedge clk);
        end
    endtask

    task automatic pulse_hr(input int n);
        repeat (n) begin
            inc_hr = 1'b1; @(negedge clk);
            inc_hr = 1'b0; @(negedge clk);
        end
    endtask

    task automatic chk_hhmm(input string name, input logic [27:0] digs);
        logic [6:0] seg;
        int         sl;
        for (int k = 3; k >= 0; k--) begin
            read_digit(k, seg, sl);
            chk($sformatf("%s_d%0d", name, k), seg, digs[k*7 +: 7]);
        end
    endtask

    initial begin
        logic [6:0] seg;
        int         sl, first_tick, n;
        bit         got;

        vt[0] = '{0,  0,  1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 5'd0};
        vt[1] = '{0,  0,  1'b1, 1'b0, {7'h79, 7'h24, 7'h40, 7'h40}, 1'b0, 5'd0};
        vt[2] = '{13, 5,  1'b1, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h12}, 1'b1, 5'd13};
        vt[3] = '{13, 5,  1'b0, 1'b0, {7'h79, 7'h30, 7'h40, 7'h12}, 1'b1, 5'd13};
        vt[4] = '{12, 34, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 5'd12};
        vt[5] = '{23, 59, 1'b0, 1'b0, {7'h24, 7'h30, 7'h12, 7'h10}, 1'b1, 5'd23};
        vt[6] = '{9,  7,  1'b1, 1'b0, {7'h7F, 7'h10, 7'h40, 7'h78}, 1'b0, 5'd9};
        vt[7] = '{23, 0,  1'b1, 1'b0, {7'h79, 7'h79, 7'h40, 7'h40}, 1'b1, 5'd23};
        vt[8] = '{5,  42, 1'b0, 1'b1, {7'h19, 7'h24, 7'h40, 7'h40}, 1'b0, 5'd5};

        // Reset hold with stray increments, then release timing.
        rst = 1'b0; mode_12h = 1'b0; show_sec = 1'b1; set_en = 1'b1; inc_min = 1'b1; inc_hr = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_display", display, 7'h7F);
        chk("rst_anode", anode, 4'hF);
        chk("rst_dp", dp, 1'b1);
        chk("rst_pm", pm, 1'b0);
        chk("rst_hours", hours, 5'd0);
        chk("rst_tick", sec_tick, 1'b0);
        set_en = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        first_tick = 0;
        for (int c = 1; c <= 15; c++) begin
            #1;
            if (sec_tick && first_tick == 0) first_tick = c;
            if (c == 2) begin
                chk("rel_anode", anode, 4'b1110);
                chk("rel_display", display, 7'h40);
            end
            @(negedge clk);
        end
        chk("first_tick_cycle", first_tick, 10);
        read_digit(0, seg, sl);
        chk("sec_after_tick", seg, 7'h79);

        // Table-driven set-mode vectors.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_en = 1'b1;
            mode_12h = vt[i].m12;
            show_sec = vt[i].ss;
            pulse_hr(vt[i].hr_n);
            pulse_min(vt[i].min_n);
            chk_hhmm($sformatf("vec%0d", i), vt[i].digs);
            chk($sformatf("vec%0d_pm", i), pm, vt[i].exp_pm);
            chk($sformatf("vec%0d_hours", i), hours, vt[i].exp_hours);
        end

        // 23:59:00 + 60 ticks rolls over to 00:00:00.
        do_reset();
        mode_12h = 1'b0; show_sec = 1'b0; set_en = 1'b1;
        pulse_min(59);
        pulse_hr(23);
        chk("set_hours", hours, 5'd23);
        chk("set_pm", pm, 1'b1);
        chk_hhmm("set2359", {7'h24, 7'h30, 7'h12, 7'h10});
        set_en = 1'b0;
        n = 0;
        for (int i = 0; i < 700 && n < 60; i++) begin
            @(negedge clk);
            if (sec_tick) n++;
        end
        chk("roll_ticks", n, 60);
        @(negedge clk);
        chk("roll_hours", hours, 5'd0);
        chk("roll_pm", pm, 1'b0);
        show_sec = 1'b1;
        read_digit(3, seg, sl); chk("roll_min_t", seg, 7'h40);
        read_digit(2, seg, sl); chk("roll_min_o", seg, 7'h40);
        read_digit(1, seg, sl); chk("roll_sec_t", seg, 7'h40);
        read_digit(0, seg, sl); chk("roll_sec_o", seg, seg_tab[sl % 10]);

        // Simultaneous increments at 05:59: minute wraps without touching the hour.
        do_reset();
        show_sec = 1'b0; set_en = 1'b1;
        pulse_hr(5);
        pulse_min(59);
        inc_min = 1'b1; inc_hr = 1'b1; @(negedge clk);
        inc_min = 1'b0; inc_hr = 1'b0; @(negedge clk);
        chk("both_hours", hours, 5'd6);
        chk_hhmm("both", {7'h40, 7'h02, 7'h40, 7'h40});

        // dp stays lit on digit 2 while the prescaler is frozen.
        wait_anode(4'b1011);
        chk("set_dp_d2", dp, 1'b0);
        wait_anode(4'b1110);
        chk("set_dp_d0", dp, 1'b1);

        // show_sec toggle at 12:34:56 while running.
        do_reset();
        show_sec = 1'b0; mode_12h = 1'b0; set_en = 1'b1;
        pulse_hr(12);
        pulse_min(34);
        set_en = 1'b0;
        chk_hhmm("run1234", {7'h79, 7'h24, 7'h30, 7'h19});
        got = 1'b0;
        for (int i = 0; i < 700 && !got; i++) begin
            @(negedge clk);
            if (m_sec == 56) got = 1'b1;
        end
        show_sec = 1'b1;
        read_digit(3, seg, sl); chk("ss_d3", seg, 7'h30);
        read_digit(2, seg, sl); chk("ss_d2", seg, 7'h19);
        read_digit(1, seg, sl); chk("ss_d1", seg, 7'h12);
        read_digit(0, seg, sl); chk("ss_d0", seg, seg_tab[sl % 10]);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("run_dp_c%0d", i), dp, !(anode == 4'b1011 && m_presc < 5));
            chk($sformatf("run_tick_c%0d", i), sec_tick, (m_presc == 9));
        end

        // Reset mid-second and mid-scan at 10:20:30 with increments held.
        do_reset();
        show_sec = 1'b0; set_en = 1'b1;
        pulse_hr(10);
        pulse_min(20);
        set_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 700 && !got; i++) begin
            @(negedge clk);
            if (m_sec == 30) got = 1'b1;
        end
        chk("mid_reached_30", got, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0; set_en = 1'b1; inc_min = 1'b1; inc_hr = 1'b1;
        @(negedge clk);
        chk("mid_display", display, 7'h7F);
        chk("mid_anode", anode, 4'hF);
        chk("mid_hours", hours, 5'd0);
        chk("mid_pm", pm, 1'b0);
        chk("mid_tick", sec_tick, 1'b0);
        chk("mid_dp", dp, 1'b1);
        @(negedge clk);
        inc_min = 1'b0; inc_hr = 1'b0;
        rst = 1'b1;
        chk_hhmm("mid_after", {7'h40, 7'h40, 7'h40, 7'h40});
        chk("mid_after_hours", hours, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/digital_clock_core.md
Name: digital_clock_core

Overview:
Parametrised successor to the existing time-of-day plus seven-segment pair. It merges both into one block with a configurable clock frequency, a BCD hours/minutes/seconds timekeeper, run-time 12/24-hour mode and time-set controls. It also has an N-digit multiplexed active-low seven-segment driver with a blinking colon point and a PM indicator. It sits directly under the board top and drives the segment and anode pins.

Parameters:
TICK_DIV, 100000000, clk cycles per second tick (set small in simulation)
SCAN_DIV, 100000, clk cycles per digit refresh slot
NUM_DIGITS, 4, number of digits driven (4 or 6 only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
mode_12h  input  1  1 = 12-hour display, 0 = 24-hour
show_sec  input  1  NUM_DIGITS=4 only: 1 = show MM:SS, 0 = show HH:MM
set_en  input  1  1 = set mode; timekeeping frozen
inc_min  input  1  single-cycle pulse; increments minutes in set mode
inc_hr  input  1  single-cycle pulse; increments hours in set mode
display  output  7  segments {g,f,e,d,c,b,a}, active-low
anode  output  NUM_DIGITS  digit enables, one-hot active-low; bit 0 = rightmost
dp  output  1  decimal point, active-low
pm  output  1  1 when hour >= 12, independent of mode_12h
hours  output  5  binary hour 0..23 for other logic
sec_tick  output  1  one-cycle pulse per second

Behaviour:
- All state changes on the rising edge of clk. When rst=0 at an edge:
  - prescaler, scan counter, digit index, sec, min and hr are cleared.
  - display=7'h7F, anode all 1, dp=1, pm=0, hours=0, sec_tick=0.
- Prescaler counts 0..TICK_DIV-1 and wraps.
  - sec_tick is asserted for exactly the cycle in which the prescaler equals TICK_DIV-1 and set_en=0.
  - While set_en=1, the prescaler is held at 0 and sec_tick stays 0.
- Timekeeping is held internally as BCD digits.
  - sec/min/hr update on the cycle after sec_tick, so registered latency is 1 cycle.
  - sec 00..59: wrap to 00 carries into min.
  - min 00..59: wrap to 00 carries into hr.
  - hr 00..23: wraps to 00 with no further carry.
  - 23:59:59 plus one tick gives 00:00:00.
- Set mode (set_en=1):
  - sec is held at 00.
  - inc_min: min = (min+1) mod 60, with no carry into hr.
  - inc_hr: hr = (hr+1) mod 24.
  - inc_min and inc_hr in the same cycle both apply.
  - inc_min and inc_hr are ignored when set_en=0.
  - Leaving set mode restarts the second at prescaler 0.
- hours output is the binary equivalent of BCD hr, registered in the same cycle as hr.
- Hour display mapping:
  - 24-hour mode: hr shown as-is.
  - 12-hour mode: 0 shows as 12; 13..23 show as 1..11.
  - 12-hour mode with a displayed hour < 10: the hour-tens digit is blanked (7'h7F).
  - pm = (hr >= 12) in both modes.
- Digit map:
  - NUM_DIGITS=6: digits 5..0 = H H M M S S.
  - NUM_DIGITS=4, show_sec=0: digits 3..0 = H H M M.
  - NUM_DIGITS=4, show_sec=1: digits 3..0 = M M S S.
- Scanner:
  - Scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances (NUM_DIGITS-1 wraps to 0).
  - anode drives the current digit low.
  - display and anode are registered together, so there is never a cycle in which the anode changes without its segment value.
  - After reset, digit 0 is the first digit selected, on the first cycle after reset release.
- dp:
  - Low (lit) only while digit 2 is selected and the prescaler is < TICK_DIV/2.
  - In set mode the prescaler is held at 0, so dp stays lit while digit 2 is selected.
- Segment encoding uses the standard active-low table. Value 0 = 7'h40, value 8 = 7'h00. Blank = 7'h7F.
- Mode inputs (mode_12h, show_sec) take effect on the next scan slot with no state corruption.
- Reset asserted mid-second or mid-scan fully clears state at that edge.

Decomposition:
- Package clock_pkg holds:
  - seg_encode function (4-bit BCD to active-low 7-bit)
  - SEG_BLANK constant (7'h7F)
  - MAX_SEC/MAX_MIN/MAX_HR constants
  - a BCD pair typedef
- One sub-module, digit_scan (parameters SCAN_DIV, NUM_DIGITS): takes the packed per-digit segment vectors and produces the registered display, anode and current digit index.
- Timekeeping and the mode mapping stay in digital_clock_core.

Test Plan:
- Reset release with TICK_DIV=10, SCAN_DIV=4 -> outputs hold their reset values while rst=0. After release, anode=4'b1110 and display=7'h40; sec_tick first pulses 10 cycles later; sec=01 the following cycle.
- Set mode: 59 inc_min pulses then 23 inc_hr pulses -> 23:59, pm=1, hours=23. Release set_en and run 60 ticks -> 00:00:00, pm=0, hours=0.
- mode_12h=1 at hr=00 shows "12"; at hr=13 shows " 1" (tens digit display=7'h7F) with pm=1; mode_12h=0 at hr=13 shows "13".
- inc_min and inc_hr in the same cycle at 05:59 in set mode -> 06:00? No: min wraps without carry, so the result is 06:00 in hours 06 and min 00, with no extra hour carry (hr goes only 05->06).
- NUM_DIGITS=4, show_sec toggled 0->1 at 12:34:56 -> digits go from 1,2,3,4 to 3,4,5,6 from the next scan slot. dp toggles at TICK_DIV/2 only while anode[2]=0.
- rst=0 asserted mid-scan at 10:20:30 -> next edge gives all counters 0, display=7'h7F, anode all 1; inc pulses during reset are ignored.
